uart_tx_word_queue: RTL and testbench

- Buffers 64-bit words from the ISA decode stage in a 10 MHz-domain FIFO.
- Meters the words one at a time into the serial UART word transmitter, which drives the DSTARB star lines.
- Sits between the ISA decoder output (tx data / tx enable) and the transmitter input (data / data_valid / tx_ready).
- Prevents words from being lost when the decoder emits bursts faster than the serial link drains them.

---
 rtl/uart_tx_word_queue_if.sv | 30 +++
 rtl/uart_tx_word_queue.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_word_queue.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_word_queue_if.sv
// Word-queue bus: decoder-side push signals, transmitter handshake and status.
// The slave modport is the queue itself; the master modport is whoever drives it.
interface uart_tx_word_queue_if #(
  parameter int AW = 4
);
  logic [63:0] I_data;
  logic        I_data_valid;
  logic        I_clr;
  logic        I_tx_ready;
  logic [63:0] O_data;
  logic        O_data_valid;
  logic [AW:0] O_level;
  logic        O_full;
  logic        O_empty;
  logic        O_overflow;
  logic [15:0] O_drop_cnt;
  logic        O_timeout;

  modport slave (
    input  I_data, I_data_valid, I_clr, I_tx_ready,
    output O_data, O_data_valid, O_level, O_full, O_empty,
           O_overflow, O_drop_cnt, O_timeout
  );

  modport master (
    output I_data, I_data_valid, I_clr, I_tx_ready,
    input  O_data, O_data_valid, O_level, O_full, O_empty,
           O_overflow, O_drop_cnt, O_timeout
  );
endinterface

// File: rtl/uart_tx_word_queue.sv
// Word queue between the ISA decoder and the serial UART word transmitter.
// Buffers decoder words in a FIFO and meters them out one at a time, waiting
// for the transmitter to go busy and idle again, plus a fixed idle gap.
module uart_tx_word_queue #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int GAP_CYCLES   = 4
) (
  input logic               I_clk_10M,
  input logic               I_rst_n,
  uart_tx_word_queue_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_GAP
  } state_t;

  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] TIMER_LAST = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] gap_q, gap_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic [63:0] mem_q [DEPTH];

  logic pop;
  logic push_ok;
  logic push_drop;

  // Pointer, occupancy and drop bookkeeping; a pop frees a slot in the same cycle.
  always_comb begin
    pop        = (state_q == S_ISSUE);
    push_ok    = bus.I_data_valid && !bus.I_clr && (!full_q || pop);
    push_drop  = bus.I_data_valid && !bus.I_clr && full_q && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.I_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
    end
    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge I_clk_10M) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.I_data;
    end
  end

  // Issue sequencing: next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && bus.I_tx_ready) begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
          data_d  = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        timer_d = '0;
      end
      S_WAIT_BUSY: begin
        if (!bus.I_tx_ready) begin
          state_d = S_WAIT_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
          gap_d     = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (bus.I_tx_ready) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (GAP_CYCLES <= 1 || gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (bus.I_clr) begin
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      timer_d   = '0;
      gap_d     = '0;
    end
  end

  // All state and outputs registered; reset aborts any issue and empties the queue.
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.O_data       = data_q;
  assign bus.O_data_valid = valid_q;
  assign bus.O_level      = level_q;
  assign bus.O_full       = full_q;
  assign bus.O_empty      = empty_q;
  assign bus.O_overflow   = overflow_q;
  assign bus.O_drop_cnt   = drop_cnt_q;
  assign bus.O_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_word_queue.sv
// Testbench for uart_tx_word_queue: directed steps with a word scoreboard
// and a simple transmitter model that goes busy for a set time per issue.
module tb_uart_tx_word_queue;

  localparam int DEPTH        = 16;
  localparam int AW           = 4;
  localparam int BUSY_TIMEOUT = 64;
  localparam int GAP_CYCLES   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int issued_cnt  = 0;
  int cyc         = 0;
  int last_issue  = -1;
  int exp_spacing = 0;
  bit spacing_on  = 1'b0;
  int busy_len    = 0;
  int busy_cnt    = 0;
  bit hold_busy   = 1'b0;
  logic [63:0] sb [$];

  // 10 MHz clock: 100 time-unit period.
  always #50 clk = ~clk;

  uart_tx_word_queue_if #(.AW(AW)) bus ();

  uart_tx_word_queue #(
    .DEPTH(DEPTH),
    .AW(AW),
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .I_clk_10M(clk),
    .I_rst_n(rst_n),
    .bus(bus)
  );

  // The transmitter reads as idle unless it is held off or still shifting a word.
  assign bus.I_tx_ready = !hold_busy && (busy_cnt == 0);

  // Transmitter model: each strobe makes it busy for busy_len cycles (0 = never busy).
  always begin
    @(posedge clk);
    #1;
    if (busy_cnt > 0) busy_cnt--;
    if (bus.O_data_valid === 1'b1 && busy_len > 0) busy_cnt = busy_len;
  end

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, leaving us just after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle push strobe; accepted words go to the scoreboard.
  task automatic applyStimulus(input logic [63:0] w, input bit accept);
    bus.I_data       = w;
    bus.I_data_valid = 1'b1;
    if (accept) sb.push_back(w);
    tick(1);
    bus.I_data_valid = 1'b0;
  endtask

  // Wait, with a cycle budget, until the issue count reaches the target.
  task automatic waitIssued(input int target, input int budget);
    int n;
    n = 0;
    while (issued_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("issue_wait", 64'(issued_cnt), 64'(target));
  endtask

  // Monitor: every issue strobe must match the scoreboard head, and optionally its spacing.
  always @(negedge clk) begin
    logic [63:0] exp;
    cyc++;
    if (bus.O_data_valid === 1'b1) begin
      issued_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", 64'(bus.O_data_valid), 64'd0);
      end else begin
        exp = sb.pop_front();
        checkOutput("issue_data", bus.O_data, exp);
        if (spacing_on && last_issue >= 0)
          checkOutput("issue_spacing", 64'(cyc - last_issue), 64'(exp_spacing));
        last_issue = cyc;
      end
    end
  end

  // Hang guard in case a bounded wait itself misbehaves.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of scenarios.
  initial begin
    int start;
    bus.I_data       = '0;
    bus.I_data_valid = 1'b0;
    bus.I_clr        = 1'b0;

    // Reset state.
    #10 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    checkOutput("rst_empty",    64'(bus.O_empty), 64'd1);
    checkOutput("rst_level",    64'(bus.O_level), 64'd0);
    checkOutput("rst_full",     64'(bus.O_full), 64'd0);
    checkOutput("rst_valid",    64'(bus.O_data_valid), 64'd0);
    checkOutput("rst_overflow", 64'(bus.O_overflow), 64'd0);
    checkOutput("rst_drop",     64'(bus.O_drop_cnt), 64'd0);
    checkOutput("rst_timeout",  64'(bus.O_timeout), 64'd0);
    checkOutput("rst_data",     bus.O_data, 64'd0);

    // Single word: strobe two cycles after the push.
    $display("[TB] single word");
    busy_len = 100;
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b1);
    checkOutput("lat_valid_c1", 64'(bus.O_data_valid), 64'd0);
    checkOutput("lat_level_c1", 64'(bus.O_level), 64'd1);
    tick(1);
    checkOutput("lat_valid_c2", 64'(bus.O_data_valid), 64'd1);
    checkOutput("lat_data_c2",  bus.O_data, 64'h0123_4567_89AB_CDEF);
    tick(1);
    checkOutput("single_level", 64'(bus.O_level), 64'd0);
    tick(110);

    // Timeout: transmitter never goes busy.
    $display("[TB] timeout");
    busy_len = 0;
    start = issued_cnt;
    applyStimulus(64'hDEAD_BEEF_0000_0001, 1'b1);
    tick(1);
    checkOutput("to_issue", 64'(bus.O_data_valid), 64'd1);
    tick(1);
    tick(BUSY_TIMEOUT - 1);
    checkOutput("to_early", 64'(bus.O_timeout), 64'd0);
    tick(1);
    checkOutput("to_pulse", 64'(bus.O_timeout), 64'd1);
    tick(1);
    checkOutput("to_after", 64'(bus.O_timeout), 64'd0);
    tick(30);
    checkOutput("to_no_reissue", 64'(issued_cnt), 64'(start + 1));

    // Burst of 20 pushes while the transmitter is busy.
    $display("[TB] burst");
    hold_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(64'hB000_0000_0000_0000 | 64'(i), i < DEPTH);
      if (i == DEPTH - 1) begin
        checkOutput("burst_full",  64'(bus.O_full), 64'd1);
        checkOutput("burst_level", 64'(bus.O_level), 64'(DEPTH));
      end
    end
    checkOutput("burst_overflow", 64'(bus.O_overflow), 64'd1);
    checkOutput("burst_drop",     64'(bus.O_drop_cnt), 64'd4);
    checkOutput("burst_level2",   64'(bus.O_level), 64'(DEPTH));
    busy_len    = 20;
    exp_spacing = busy_len + GAP_CYCLES + 2;
    last_issue  = -1;
    spacing_on  = 1'b1;
    start       = issued_cnt;
    hold_busy   = 1'b0;
    waitIssued(start + DEPTH, 1000);
    tick(30);
    spacing_on = 1'b0;
    checkOutput("burst_drained", 64'(sb.size()), 64'd0);
    checkOutput("burst_empty",   64'(bus.O_empty), 64'd1);

    // Clear, then fill and push on the issue cycle while full.
    $display("[TB] full with push and pop");
    bus.I_clr = 1'b1;
    tick(1);
    bus.I_clr = 1'b0;
    checkOutput("clr_overflow", 64'(bus.O_overflow), 64'd0);
    checkOutput("clr_drop",     64'(bus.O_drop_cnt), 64'd0);
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) applyStimulus(64'hF000_0000_0000_0000 | 64'(i), 1'b1);
    busy_len  = 5;
    start     = issued_cnt;
    hold_busy = 1'b0;
    tick(1);
    checkOutput("pp_issue", 64'(bus.O_data_valid), 64'd1);
    applyStimulus(64'hF000_0000_0000_00FF, 1'b1);
    checkOutput("pp_level",    64'(bus.O_level), 64'(DEPTH));
    checkOutput("pp_full",     64'(bus.O_full), 64'd1);
    checkOutput("pp_drop",     64'(bus.O_drop_cnt), 64'd0);
    checkOutput("pp_overflow", 64'(bus.O_overflow), 64'd0);
    waitIssued(start + DEPTH + 1, 400);
    tick(20);

    // Reset while waiting for the transmitter with 5 words queued.
    $display("[TB] reset mid-operation");
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(64'h5000_0000_0000_0000 | 64'(i), i == 0);
    busy_len  = 50;
    start     = issued_cnt;
    hold_busy = 1'b0;
    waitIssued(start + 1, 20);
    tick(2);
    checkOutput("mid_level", 64'(bus.O_level), 64'd5);
    #20 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.O_data_valid), 64'd0);
    checkOutput("mid_rst_level", 64'(bus.O_level), 64'd0);
    checkOutput("mid_rst_empty", 64'(bus.O_empty), 64'd1);
    checkOutput("mid_rst_full",  64'(bus.O_full), 64'd0);
    checkOutput("mid_rst_data",  bus.O_data, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(100);
    checkOutput("mid_no_strobe", 64'(issued_cnt), 64'(start + 1));
    applyStimulus(64'h5000_0000_0000_00AA, 1'b1);
    waitIssued(start + 2, 20);
    tick(60);

    // Wrap-around: 40 words, each drained before the next.
    $display("[TB] wrap-around");
    busy_len = 3;
    start    = issued_cnt;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0001_0001_0001, 1'b1);
      waitIssued(start + i + 1, 20);
      tick(10);
    end
    checkOutput("wrap_drop",     64'(bus.O_drop_cnt), 64'd0);
    checkOutput("wrap_overflow", 64'(bus.O_overflow), 64'd0);
    checkOutput("wrap_empty",    64'(bus.O_empty), 64'd1);
    checkOutput("wrap_sb",       64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
